vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen.sv | 119 +++++++++++
 tb/tb_vga_timing_gen.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 Hz VGA raster timing generator.
// A divider turns the system clock into a pixel rate. Horizontal and vertical
// counters walk the raster. HS, VS and blanking are registered from the
// next-state counter values, so they line up with the coordinate outputs.
// Optional feature: define VGA_FRAME_CNT_EN to add the 16-bit oFrame_cnt output.

module vga_timing_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic        CLK,
    input  logic        RESETn,
    output logic [10:0] oCoord_X,
    output logic [10:0] oCoord_Y,
    output logic        oHS,
    output logic        oVS,
    output logic        oBLANK_n,
    output logic        oPixel_en,
`ifdef VGA_FRAME_CNT_EN
    output logic        oSOF,
    output logic [15:0] oFrame_cnt
`else
    output logic        oSOF
`endif
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] HS_START = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [10:0] VS_START = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [DIV_W-1:0] div_cnt, div_nxt;
    logic [10:0]      h_cnt, h_nxt;
    logic [10:0]      v_cnt, v_nxt;
    logic             pix_adv;
    logic             pen_nxt;
    logic             hs_q, vs_q, blank_q, pen_q, sof_q;

    // Next-state counters: the pixel advances when the divider hits its last
    // phase, and the line advances only on the horizontal wrap.
    always_comb begin
        pix_adv = (div_cnt == DIV_LAST);
        div_nxt = pix_adv ? '0 : div_cnt + DIV_W'(1);
        h_nxt   = h_cnt;
        v_nxt   = v_cnt;
        if (pix_adv) begin
            if (h_cnt == H_LAST) begin
                h_nxt = '0;
                v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + 11'd1;
            end else begin
                h_nxt = h_cnt + 11'd1;
            end
        end
        pen_nxt = (div_nxt == DIV_LAST);
    end

    // Counters and decoded outputs share one register stage so they stay cycle-aligned.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            div_cnt <= '0;
            h_cnt   <= '0;
            v_cnt   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
            blank_q <= 1'b0;
            pen_q   <= 1'b0;
            sof_q   <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            hs_q    <= !((h_nxt >= HS_START) && (h_nxt <= HS_END));
            vs_q    <= !((v_nxt >= VS_START) && (v_nxt <= VS_END));
            blank_q <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
            pen_q   <= pen_nxt;
            sof_q   <= pen_nxt && (h_nxt == H_LAST) && (v_nxt == V_LAST);
        end
    end

    assign oCoord_X  = h_cnt;
    assign oCoord_Y  = v_cnt;
    assign oHS       = hs_q;
    assign oVS       = vs_q;
    assign oBLANK_n  = blank_q;
    assign oPixel_en = pen_q;
    assign oSOF      = sof_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt;

    // Frame counter steps on the edge that closes each start-of-frame cycle.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            frame_cnt <= '0;
        end else if (sof_q) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end

    assign oFrame_cnt = frame_cnt;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen: one default-geometry instance plus two
// small-geometry instances (CLK_DIV=3 and CLK_DIV=1) so whole frames fit
// in a short run. Define VGA_FRAME_CNT_EN to also exercise oFrame_cnt.

module tb_vga_timing_gen;

    localparam int S_HV = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VV = 6, S_VF = 1, S_VS = 2, S_VB = 1;

    logic CLK = 1'b0;
    logic RESETn;

    logic [10:0] def_x, def_y, sm_x, sm_y, d1_x, d1_y;
    logic def_hs, def_vs, def_bl, def_pen, def_sof;
    logic sm_hs, sm_vs, sm_bl, sm_pen, sm_sof;
    logic d1_hs, d1_vs, d1_bl, d1_pen, d1_sof;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0] def_fc, sm_fc, d1_fc;
`endif

    int n;
    int total;
    int bad;
    int fc_base_div1;
    int fc_ref_div1;
    int hs_low, blank_hi, sm_sof_cnt, sm_vs_low, sm_hs_low, d1_sof_cnt, d1_vs_low;

    typedef struct {
        int          n;
        logic [10:0] x;
        logic [10:0] y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        pen;
        logic        sof;
    } vec_t;

    vec_t vecs[13];

    always #5 CLK = ~CLK;

    vga_timing_gen dut_def (
        .CLK(CLK), .RESETn(RESETn),
        .oCoord_X(def_x), .oCoord_Y(def_y),
        .oHS(def_hs), .oVS(def_vs), .oBLANK_n(def_bl),
        .oPixel_en(def_pen),
`ifdef VGA_FRAME_CNT_EN
        .oSOF(def_sof), .oFrame_cnt(def_fc)
`else
        .oSOF(def_sof)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(3),
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_small (
        .CLK(CLK), .RESETn(RESETn),
        .oCoord_X(sm_x), .oCoord_Y(sm_y),
        .oHS(sm_hs), .oVS(sm_vs), .oBLANK_n(sm_bl),
        .oPixel_en(sm_pen),
`ifdef VGA_FRAME_CNT_EN
        .oSOF(sm_sof), .oFrame_cnt(sm_fc)
`else
        .oSOF(sm_sof)
`endif
    );

    vga_timing_gen #(
        .CLK_DIV(1),
        .H_VISIBLE(S_HV), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
        .V_VISIBLE(S_VV), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
    ) dut_div1 (
        .CLK(CLK), .RESETn(RESETn),
        .oCoord_X(d1_x), .oCoord_Y(d1_y),
        .oHS(d1_hs), .oVS(d1_vs), .oBLANK_n(d1_bl),
        .oPixel_en(d1_pen),
`ifdef VGA_FRAME_CNT_EN
        .oSOF(d1_sof), .oFrame_cnt(d1_fc)
`else
        .oSOF(d1_sof)
`endif
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s n=%0d got=%0d want=%0d", name, n, act, exp);
        end
    endtask

    // Reference: everything follows from the number of CLK edges since reset release.
    task automatic checkInst(input string tag, input int d,
                             input int hv, input int hf, input int hsw, input int hb,
                             input int vv, input int vf, input int vsw, input int vb,
                             input logic [10:0] x, input logic [10:0] y,
                             input logic hs, input logic vs, input logic bl,
                             input logic pen, input logic sof);
        int ht, vt, p, ex, ey;
        logic ehs, evs, ebl, epen, esof;
        ht = hv + hf + hsw + hb;
        vt = vv + vf + vsw + vb;
        if (n == 0) begin
            ex = 0; ey = 0; ehs = 1'b1; evs = 1'b1; ebl = 1'b0; epen = 1'b0; esof = 1'b0;
        end else begin
            p    = n / d;
            ex   = p % ht;
            ey   = (p / ht) % vt;
            ehs  = !(ex >= hv + hf && ex < hv + hf + hsw);
            evs  = !(ey >= vv + vf && ey < vv + vf + vsw);
            ebl  = (ex < hv) && (ey < vv);
            epen = ((n % d) == d - 1);
            esof = epen && (ex == ht - 1) && (ey == vt - 1);
        end
        checkOutput({tag, ".X"}, x, ex);
        checkOutput({tag, ".Y"}, y, ey);
        checkOutput({tag, ".HS"}, hs, ehs);
        checkOutput({tag, ".VS"}, vs, evs);
        checkOutput({tag, ".BLANK_n"}, bl, ebl);
        checkOutput({tag, ".PIXEL_EN"}, pen, epen);
        checkOutput({tag, ".SOF"}, sof, esof);
    endtask

`ifdef VGA_FRAME_CNT_EN
    task automatic checkFrameCnt(input string tag, input int d, input int ht, input int vt,
                                 input logic [15:0] fc, input int base, input int ref_n);
        int fp;
        fp = ht * vt * d;
        checkOutput({tag, ".FRAME_CNT"}, fc, (base + n / fp - ref_n / fp) & 16'hFFFF);
    endtask
`endif

    task automatic checkAll();
        checkInst("def", 2, 640, 16, 96, 48, 480, 10, 2, 33,
                  def_x, def_y, def_hs, def_vs, def_bl, def_pen, def_sof);
        checkInst("small", 3, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                  sm_x, sm_y, sm_hs, sm_vs, sm_bl, sm_pen, sm_sof);
        checkInst("div1", 1, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB,
                  d1_x, d1_y, d1_hs, d1_vs, d1_bl, d1_pen, d1_sof);
`ifdef VGA_FRAME_CNT_EN
        checkFrameCnt("def", 2, 800, 525, def_fc, 0, 0);
        checkFrameCnt("small", 3, 15, 10, sm_fc, 0, 0);
        checkFrameCnt("div1", 1, 15, 10, d1_fc, fc_base_div1, fc_ref_div1);
`endif
    endtask

    task automatic applyStimulus(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            checkAll();
        end
    endtask

    task automatic holdReset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            checkAll();
        end
    endtask

    // Drops RESETn between clock edges and checks the outputs before any edge arrives.
    task automatic assertReset(input int offset);
        #(offset);
        RESETn = 1'b0;
        #1;
        n = 0;
        fc_base_div1 = 0;
        fc_ref_div1 = 0;
        checkAll();
    endtask

    task automatic releaseReset();
        @(negedge CLK);
        #2;
        RESETn = 1'b1;
        n = 0;
    endtask

    initial begin
        RESETn = 1'b0;
        n = 0;
        total = 0;
        bad = 0;
        fc_base_div1 = 0;
        fc_ref_div1 = 0;

        //          n     X    Y  HS VS BL PEN SOF
        vecs[0]  = '{0,    0,   0, 1, 1, 0, 0, 0};
        vecs[1]  = '{1,    0,   0, 1, 1, 1, 1, 0};
        vecs[2]  = '{2,    1,   0, 1, 1, 1, 0, 0};
        vecs[3]  = '{3,    1,   0, 1, 1, 1, 1, 0};
        vecs[4]  = '{1279, 639, 0, 1, 1, 1, 1, 0};
        vecs[5]  = '{1280, 640, 0, 1, 1, 0, 0, 0};
        vecs[6]  = '{1311, 655, 0, 1, 1, 0, 1, 0};
        vecs[7]  = '{1312, 656, 0, 0, 1, 0, 0, 0};
        vecs[8]  = '{1503, 751, 0, 0, 1, 0, 1, 0};
        vecs[9]  = '{1504, 752, 0, 1, 1, 0, 0, 0};
        vecs[10] = '{1599, 799, 0, 1, 1, 0, 1, 0};
        vecs[11] = '{1600, 0,   1, 1, 1, 1, 0, 0};
        vecs[12] = '{1601, 0,   1, 1, 1, 1, 1, 0};

        holdReset(3);
        releaseReset();

        $display("[TB] default-geometry vectors from reset release");
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i].n - n);
            checkOutput($sformatf("vec%0d.X", i), def_x, vecs[i].x);
            checkOutput($sformatf("vec%0d.Y", i), def_y, vecs[i].y);
            checkOutput($sformatf("vec%0d.HS", i), def_hs, vecs[i].hs);
            checkOutput($sformatf("vec%0d.VS", i), def_vs, vecs[i].vs);
            checkOutput($sformatf("vec%0d.BLANK_n", i), def_bl, vecs[i].bl);
            checkOutput($sformatf("vec%0d.PIXEL_EN", i), def_pen, vecs[i].pen);
            checkOutput($sformatf("vec%0d.SOF", i), def_sof, vecs[i].sof);
        end

        $display("[TB] one line period of the default instance");
        hs_low = 0;
        blank_hi = 0;
        for (int i = 0; i < 1600; i++) begin
            applyStimulus(1);
            if (def_hs == 1'b0) hs_low++;
            if (def_bl == 1'b1) blank_hi++;
        end
        checkOutput("line.hs_low_clks", hs_low, 192);
        checkOutput("line.visible_clks", blank_hi, 1280);

        $display("[TB] three small frames / nine div1 frames");
        sm_sof_cnt = 0; sm_vs_low = 0; sm_hs_low = 0; d1_sof_cnt = 0; d1_vs_low = 0;
        for (int i = 0; i < 1350; i++) begin
            applyStimulus(1);
            if (sm_sof == 1'b1) sm_sof_cnt++;
            if (sm_vs == 1'b0) sm_vs_low++;
            if (sm_hs == 1'b0) sm_hs_low++;
            if (d1_sof == 1'b1) d1_sof_cnt++;
            if (d1_vs == 1'b0) d1_vs_low++;
        end
        checkOutput("small.sof_count", sm_sof_cnt, 3);
        checkOutput("small.vs_low_clks", sm_vs_low, 270);
        checkOutput("small.hs_low_clks", sm_hs_low, 270);
        checkOutput("div1.sof_count", d1_sof_cnt, 9);
        checkOutput("div1.vs_low_clks", d1_vs_low, 270);

        $display("[TB] asynchronous reset inside horizontal sync");
        assertReset(2);
        holdReset(2);
        releaseReset();
        applyStimulus(1400);
        checkOutput("pre_rst.X", def_x, 700);
        checkOutput("pre_rst.HS", def_hs, 1'b0);
        assertReset(2);
        checkOutput("async_rst.X", def_x, 0);
        checkOutput("async_rst.Y", def_y, 0);
        checkOutput("async_rst.HS", def_hs, 1'b1);
        checkOutput("async_rst.BLANK_n", def_bl, 1'b0);
        checkOutput("async_rst.PIXEL_EN", def_pen, 1'b0);
        holdReset(2);
        releaseReset();

        $display("[TB] randomized reset points");
        for (int k = 0; k < 6; k++) begin
            applyStimulus(int'($urandom_range(2500, 20)));
            assertReset(int'($urandom_range(3, 1)));
            holdReset(int'($urandom_range(3, 1)));
            releaseReset();
        end

`ifdef VGA_FRAME_CNT_EN
        $display("[TB] frame counter and wrap");
        applyStimulus(450);
        checkOutput("div1.fc_after_3", d1_fc, 3);
        force dut_div1.frame_cnt = 16'hFFFF;
        #1;
        release dut_div1.frame_cnt;
        fc_base_div1 = 65535;
        fc_ref_div1 = n;
        applyStimulus(150);
        checkOutput("div1.fc_wrap", d1_fc, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
